addsub_nibble_seq: RTL and testbench
====================================

Name: addsub_nibble_seq

Overview:
- Multi-cycle controller that reuses one 4-bit ripple add/subtract stage to add or subtract WIDTH-bit operands, one nibble per clock, LSB nibble first.
- Sits between a requester (valid/ready command side) and a consumer (valid/ready result side).
- Owns the operand capture, the nibble counter, the inter-nibble carry register and result assembly.
- The 4-bit stage is internal: {c_out, s} = a_nib + (b_nib XOR {4{mode}}) + c_in.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIBS, WIDTH/4, derived number of nibble steps; not overridden by users.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  requester presents an operation
- cmd_ready  output  1  block can accept a command; high only in IDLE
- a  input  WIDTH  operand A, sampled on command accept
- b  input  WIDTH  operand B, sampled on command accept
- mode  input  1  0 = add (A+B), 1 = subtract (A-B), sampled on accept
- res_valid  output  1  result outputs valid
- res_ready  input  1  consumer takes the result
- sum  output  WIDTH  result
- carry  output  1  final carry out; for subtract, 1 = no borrow (A >= B unsigned)
- overflow  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, nibble counter = 0, carry register = 0.
  - sum = 0, carry = 0, overflow = 0, res_valid = 0, busy = 0.
  - cmd_ready = 1, derived from IDLE state.
  - Inputs are ignored while rst_n is low.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready = 1.
  - On a clock edge with cmd_valid = 1: capture a, b, mode; carry register = mode (supplies the +1 of two's complement); counter = 0; go to RUN.
- RUN:
  - cmd_ready = 0.
  - Each edge processes nibble k = counter: writes sum[4k+3:4k] and updates the carry register with c_out.
  - On the last nibble (k = NIBS-1), record overflow = (carry into bit WIDTH-1) XOR c_out and carry = c_out, then go to DONE.
  - Otherwise counter increments.
- DONE:
  - res_valid = 1.
  - sum, carry and overflow stay stable until an edge with res_ready = 1, then go to IDLE with res_valid = 0.
  - The next command can be accepted one cycle after the result handoff; there is no same-cycle turnaround.
- Latency: the command accept edge is T. res_valid is high after edge T+NIBS, i.e. 4 cycles for WIDTH = 16.
- Throughput: one operation per NIBS+2 cycles minimum.
- Held result: sum/carry/overflow keep the previous result through IDLE until the next final nibble writes them. Intermediate nibbles of sum may change during RUN; they are valid only when res_valid = 1.
- cmd_valid while not in IDLE is ignored, with no queueing. The requester must hold cmd_valid until cmd_ready is seen.
- res_ready while res_valid = 0 has no effect.
- Wrap-around: arithmetic is modulo 2^WIDTH; carry and overflow report the out-of-range cases.
- Reset during RUN or DONE aborts the operation. The partial result is discarded and all outputs take their reset values immediately.
- Width rules:
  - b is inverted per nibble only when mode = 1.
  - The carry register is 1 bit; the counter is ceil(log2(NIBS)) bits, minimum 1.

Test Plan:
- Add, no carry: a=16'h1234, b=16'h0FFF, mode=0 -> after 4 cycles res_valid=1, sum=16'h2233, carry=0, overflow=0.
- Subtract: a=16'h000D, b=16'h0003, mode=1 -> sum=16'h000A, carry=1. Then a=16'h0003, b=16'h000D, mode=1 -> sum=16'hFFF6, carry=0, overflow=0.
- Overflow and wrap:
  - a=16'h7FFF, b=16'h0001, add -> sum=16'h8000, overflow=1, carry=0.
  - a=16'hFFFF, b=16'h0001, add -> sum=16'h0000, carry=1, overflow=0.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid -> sum/carry/overflow stable, cmd_ready=0. A new cmd_valid pulse in this window is ignored. Raising res_ready gives IDLE on the next edge.
- Reset mid-operation: deassert rst_n two cycles after accepting 16'hAAAA+16'h5555 -> outputs immediately 0, cmd_ready=1. After release, a fresh 16'h0001+16'h0001 -> sum=16'h0002.
- Back-to-back: three commands with res_ready tied high -> each result appears NIBS cycles after its accept, with no corruption of the carry register between operations.

Source files
------------

// File: rtl/addsub_nibble_seq_if.sv
// Command/result bundle for the nibble-serial add/subtract sequencer.
// The master side is the requester and consumer. The slave side is the sequencer.
interface addsub_nibble_seq_if #(
  parameter int WIDTH = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             busy;

  modport master (
    output cmd_valid, a, b, mode, res_ready,
    input  cmd_ready, res_valid, sum, carry, overflow, busy
  );

  modport slave (
    input  cmd_valid, a, b, mode, res_ready,
    output cmd_ready, res_valid, sum, carry, overflow, busy
  );
endinterface

// File: rtl/addsub_nibble_seq.sv
// Adds or subtracts WIDTH-bit operands through one shared 4-bit stage, LSB nibble first.
//   state | meaning
//   IDLE  | cmd_ready high; accepts and captures the next command
//   RUN   | one nibble per clock through the shared stage
//   DONE  | res_valid high; result held until res_ready
module addsub_nibble_seq #(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  addsub_nibble_seq_if.slave bus
);
  localparam int NIBS  = WIDTH / 4;
  localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               cy_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               mode_q;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, ovf_q;

  logic [3:0]         a_nib, b_raw, b_nib, s_nib;
  logic [4:0]         stage;
  logic               c_out, c_msb, last;

  always_comb begin
    a_nib = '0;
    b_raw = '0;
    for (int i = 0; i < NIBS; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_raw = b_q[4*i +: 4];
      end
    end
  end

  assign b_nib = b_raw ^ {4{mode_q}};
  assign stage = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, cy_q};
  assign s_nib = stage[3:0];
  assign c_out = stage[4];
  // Carry into the top bit of the nibble is recovered from its sum bit.
  assign c_msb = a_nib[3] ^ b_nib[3] ^ s_nib[3];
  assign last  = (cnt_q == CNT_W'(NIBS - 1));

  always_comb begin
    sum_d = sum_q;
    for (int i = 0; i < NIBS; i++) begin
      if (cnt_q == CNT_W'(i)) sum_d[4*i +: 4] = s_nib;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.res_valid = 1'b1;
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      cy_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            mode_q <= bus.mode;
            // A subtract is A + ~B + 1, so the +1 enters as the first carry-in.
            cy_q   <= bus.mode;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          sum_q <= sum_d;
          cy_q  <= c_out;
          if (last) begin
            carry_q <= c_out;
            ovf_q   <= c_msb ^ c_out;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum      = sum_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_addsub_nibble_seq.sv
// Directed bench for addsub_nibble_seq. Expected results are hand-computed constants.
module tb_addsub_nibble_seq;
  localparam int WIDTH = 16;
  localparam int NIBS  = WIDTH / 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  addsub_nibble_seq_if #(.WIDTH(WIDTH)) bus ();

  addsub_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command and collect its result. If tied is set, res_ready stays high throughout.
  // Otherwise res_ready is held low for hold cycles and a stray command is offered meanwhile.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic m, input logic [15:0] es, input logic ec,
                       input logic ev, input int hold, input logic tied);
    int n;
    chk({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    bus.a = av;
    bus.b = bv;
    bus.mode = m;
    bus.cmd_valid = 1'b1;
    bus.res_ready = tied;
    tick();
    bus.cmd_valid = 1'b0;
    bus.a = 16'hDEAD;
    bus.b = 16'hBEEF;
    bus.mode = ~m;
    chk({tag, " busy"}, 32'(bus.busy), 32'd1);
    n = 0;
    while (!bus.res_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(NIBS));
    chk({tag, " sum"}, 32'(bus.sum), 32'(es));
    chk({tag, " carry"}, 32'(bus.carry), 32'(ec));
    chk({tag, " overflow"}, 32'(bus.overflow), 32'(ev));
    for (int i = 0; i < hold; i++) begin
      bus.cmd_valid = (i == 0);
      tick();
      bus.cmd_valid = 1'b0;
      chk({tag, " hold res_valid"}, 32'(bus.res_valid), 32'd1);
      chk({tag, " hold cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
      chk({tag, " hold sum"}, 32'(bus.sum), 32'(es));
      chk({tag, " hold flags"}, {30'd0, bus.carry, bus.overflow}, {30'd0, ec, ev});
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = tied;
    chk({tag, " handoff res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, " handoff cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, " held sum"}, 32'(bus.sum), 32'(es));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    bus.mode = 1'b0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    chk("rst cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst sum", 32'(bus.sum), 32'd0);
    chk("rst flags", {30'd0, bus.carry, bus.overflow}, 32'd0);
    bus.cmd_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle after rst", 32'(bus.busy), 32'd0);

    do_op("add",   16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0, 1'b0);
    do_op("sub",   16'h000D, 16'h0003, 1'b1, 16'h000A, 1'b1, 1'b0, 0, 1'b0);
    do_op("subneg",16'h0003, 16'h000D, 1'b1, 16'hFFF6, 1'b0, 1'b0, 0, 1'b0);
    tick();
    do_op("ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 5, 1'b0);
    tick();
    do_op("wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    tick();

    bus.a = 16'hAAAA;
    bus.b = 16'h5555;
    bus.mode = 1'b0;
    bus.cmd_valid = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort sum", 32'(bus.sum), 32'd0);
    chk("abort flags", {30'd0, bus.carry, bus.overflow}, 32'd0);
    chk("abort cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("abort res_valid", 32'(bus.res_valid), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0, 1'b0);

    do_op("b2b_0", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 0, 1'b1);
    do_op("b2b_1", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0, 1'b1);
    do_op("b2b_2", 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0, 0, 1'b1);
    bus.res_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
